// File: rtl/iq_stream_pkg.sv
// Shared types and constants for the I/Q SPI streamer.
// Optional header word support is selected with the IQ_STREAM_HEADER_EN macro.
package iq_stream_pkg;

    // Serialiser FSM states.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    // Header word fields.
    localparam logic [7:0] HDR_SYNC    = 8'hA5;
    localparam int         HDR_SEQ_W   = 16;
    localparam int         HDR_SEQ_LSB = 8;

    // Width of an index that addresses every I/Q word of a frame.
    function automatic int word_idx_w(input int channels);
        return $clog2(2 * channels);
    endfunction

    // Bits of I/Q payload in one frame.
    function automatic int frame_w(input int channels, input int sample_w);
        return channels * 2 * sample_w;
    endfunction

    // FIFO entry: payload plus the channel mask captured with it.
    function automatic int entry_w(input int channels, input int sample_w);
        return frame_w(channels, sample_w) + channels;
    endfunction

endpackage

// File: rtl/iq_frame_fifo.sv
// Synchronous frame FIFO with full/empty/level.
// A push into a full FIFO is accepted when a pop happens on the same edge.
module iq_frame_fifo #(
    parameter int WIDTH = 130,
    parameter int DEPTH = 4
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage write; entries are only read once a pointer has covered them.
    // NOTE: the array has no reset -- contents are dead until written, and resetting it would cost a reset net per bit.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Read/write pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/iq_spi_streamer.sv
// Multi-channel I/Q frame buffer and word serialiser for the bus SPI shifter.
// Define IQ_STREAM_HEADER_EN to precede every frame with a sync/sequence/mask header word.
module iq_spi_streamer
    import iq_stream_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int SAMPLE_W   = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk_in,
    input  logic                            reset,
    input  logic                            iq_valid,
    input  logic [CHANNELS*2*SAMPLE_W-1:0]  iq_data,
    input  logic [CHANNELS-1:0]             chan_enable,
    input  logic                            BUS_SPI_busy,
    output logic [SAMPLE_W-1:0]             BUS_SPI_data_out,
    output logic                            BUS_SPI_enable,
    output logic                            IQ_RX_READ_REQ,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [15:0]                     overflow_count
);

    localparam int FRAME_W = frame_w(CHANNELS, SAMPLE_W);
    localparam int ENTRY_W = entry_w(CHANNELS, SAMPLE_W);
    localparam int IDX_W   = word_idx_w(CHANNELS);
    localparam int NWORDS  = 2 * CHANNELS;

    state_t              state;
    logic [FRAME_W-1:0]  frame_q;
    logic [CHANNELS-1:0] mask_q;
    logic [IDX_W:0]      search_base;

    logic                push_req;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  fifo_rd;

    logic                word_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [SAMPLE_W-1:0] word_sel;
    logic [IDX_W:0]      next_base;

    assign push_req = iq_valid && (|chan_enable);
    assign fifo_pop = (state == IDLE) && !fifo_empty;

    iq_frame_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in  (clk_in),
        .reset   (reset),
        .push    (push_req),
        .pop     (fifo_pop),
        .wr_data ({chan_enable, iq_data}),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Lowest enabled word index at or above search_base (I and Q share their channel's mask bit).
    // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
    always_comb begin
        word_found = 1'b0;
        sel_idx    = '0;
        for (int i = NWORDS - 1; i >= 0; i--) begin
            if (i >= int'(search_base) && mask_q[i/2]) begin
                word_found = 1'b1;
                sel_idx    = IDX_W'(i);
            end
        end
    end

    assign word_sel  = frame_q[sel_idx*SAMPLE_W +: SAMPLE_W];
    assign next_base = {1'b0, sel_idx} + 1'b1;

`ifdef IQ_STREAM_HEADER_EN
    logic [HDR_SEQ_W-1:0] seq_q;
    logic [SAMPLE_W-1:0]  hdr_word;

    // Header word: sync byte on top, sequence number, zero-extended channel mask.
    always_comb begin
        hdr_word                                     = '0;
        hdr_word[SAMPLE_W-1 -: 8]                    = HDR_SYNC;
        hdr_word[HDR_SEQ_LSB +: HDR_SEQ_W]           = seq_q;
        hdr_word[CHANNELS-1:0]                       = mask_q;
    end
`endif

    // Dropped-frame counter: a push into a full FIFO with no pop on the same edge, saturating.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            overflow_count <= '0;
        end else if (push_req && fifo_full && !fifo_pop && overflow_count != 16'hFFFF) begin
            overflow_count <= overflow_count + 1'b1;
        end
    end

    // Serialiser FSM: pop a frame, then hand each enabled word to the shifter over enable/busy.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state            <= IDLE;
            frame_q          <= '0;
            mask_q           <= '0;
            search_base      <= '0;
            BUS_SPI_data_out <= '0;
            BUS_SPI_enable   <= 1'b0;
            IQ_RX_READ_REQ   <= 1'b0;
`ifdef IQ_STREAM_HEADER_EN
            seq_q            <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        frame_q        <= fifo_rd[FRAME_W-1:0];
                        mask_q         <= fifo_rd[ENTRY_W-1:FRAME_W];
                        search_base    <= '0;
                        IQ_RX_READ_REQ <= 1'b1;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
`ifdef IQ_STREAM_HEADER_EN
                    BUS_SPI_data_out <= hdr_word;
                    seq_q            <= seq_q + 1'b1;
`else
                    BUS_SPI_data_out <= word_sel;
                    search_base      <= next_base;
`endif
                    BUS_SPI_enable   <= 1'b1;
                    state            <= START;
                end
                START: begin
                    BUS_SPI_enable <= 1'b1;
                    state          <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (BUS_SPI_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!BUS_SPI_busy) begin
                        BUS_SPI_enable <= 1'b0;
                        if (word_found) begin
                            BUS_SPI_data_out <= word_sel;
                            search_base      <= next_base;
                            state            <= START;
                        end else begin
                            IQ_RX_READ_REQ <= 1'b0;
                            state          <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_spi_streamer.sv
// Self-checking bench for iq_spi_streamer (CHANNELS=2, SAMPLE_W=32, FIFO_DEPTH=4).
// Build with IQ_STREAM_HEADER_EN defined to exercise the header variant.
module tb_iq_spi_streamer;

    localparam int CH    = 2;
    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic              clk_in;
    logic              reset;
    logic              iq_valid;
    logic [CH*2*W-1:0] iq_data;
    logic [CH-1:0]     chan_enable;
    logic              BUS_SPI_busy;
    logic [W-1:0]      BUS_SPI_data_out;
    logic              BUS_SPI_enable;
    logic              IQ_RX_READ_REQ;
    logic [2:0]        fifo_level;
    logic [15:0]       overflow_count;

    iq_spi_streamer #(
        .CHANNELS   (CH),
        .SAMPLE_W   (W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_in           (clk_in),
        .reset            (reset),
        .iq_valid         (iq_valid),
        .iq_data          (iq_data),
        .chan_enable      (chan_enable),
        .BUS_SPI_busy     (BUS_SPI_busy),
        .BUS_SPI_data_out (BUS_SPI_data_out),
        .BUS_SPI_enable   (BUS_SPI_enable),
        .IQ_RX_READ_REQ   (IQ_RX_READ_REQ),
        .fifo_level       (fifo_level),
        .overflow_count   (overflow_count)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- shifter model ----------------
    logic hold_busy = 1'b0;
    logic mute_busy = 1'b0;

    initial begin
        int  cnt;
        logic served;
        cnt = 0;
        served = 1'b0;
        BUS_SPI_busy = 1'b0;
        forever begin
            @(negedge clk_in);
            if (reset) begin
                BUS_SPI_busy = 1'b0;
                cnt = 0;
                served = 1'b0;
            end else if (hold_busy) begin
                BUS_SPI_busy = 1'b1;
            end else if (mute_busy) begin
                BUS_SPI_busy = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                BUS_SPI_busy = (cnt != 0);
            end else if (BUS_SPI_enable && !served) begin
                BUS_SPI_busy = 1'b1;
                cnt = 3;
                served = 1'b1;
            end else begin
                BUS_SPI_busy = 1'b0;
            end
            if (!BUS_SPI_enable) served = 1'b0;
        end
    end

    // ---------------- behavioural model and compare ----------------
    logic              cap_rst;
    logic              cap_push;
    logic [CH-1:0]     cap_mask;
    logic [CH*2*W-1:0] cap_data;

    initial begin
        forever begin
            @(posedge clk_in);
            cap_rst  = reset;
            cap_push = iq_valid;
            cap_mask = chan_enable;
            cap_data = iq_data;
        end
    end

    logic [CH*2*W-1:0] mdl_data[$];
    logic [CH-1:0]     mdl_mask[$];
    logic [W-1:0]      exp_words[$];
    logic [W-1:0]      seen[$];
    logic [W-1:0]      want[$];
    int                mdl_ovf = 0;
    int                mdl_seq = 0;

    initial begin
        logic         prev_req;
        logic         prev_en;
        logic [W-1:0] held;
        logic         popped;
        int           lvl_before;
        logic [CH*2*W-1:0] f;
        logic [CH-1:0]     m;
        prev_req = 1'b0;
        prev_en  = 1'b0;
        held     = '0;
        forever begin
            @(negedge clk_in);
            if (cap_rst) begin
                mdl_data.delete();
                mdl_mask.delete();
                exp_words.delete();
                mdl_ovf  = 0;
                mdl_seq  = 0;
                prev_req = 1'b0;
                prev_en  = 1'b0;
                check("rst_enable", {63'd0, BUS_SPI_enable}, 64'd0);
                check("rst_req", {63'd0, IQ_RX_READ_REQ}, 64'd0);
                check("rst_data", {32'd0, BUS_SPI_data_out}, 64'd0);
            end else begin
                popped     = IQ_RX_READ_REQ && !prev_req;
                lvl_before = mdl_data.size();
                if (cap_push && cap_mask != '0) begin
                    if (lvl_before < DEPTH || popped) begin
                        mdl_data.push_back(cap_data);
                        mdl_mask.push_back(cap_mask);
                    end else if (mdl_ovf < 65535) begin
                        mdl_ovf++;
                    end
                end
                if (popped) begin
                    if (mdl_data.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_empty actual=frame_started required=no_frame at %0t", $time);
                    end else begin
                        f = mdl_data.pop_front();
                        m = mdl_mask.pop_front();
`ifdef IQ_STREAM_HEADER_EN
                        exp_words.push_back({8'hA5, 16'(mdl_seq), 8'(m)});
                        mdl_seq = (mdl_seq + 1) % 65536;
`endif
                        for (int c = 0; c < CH; c++) begin
                            if (m[c]) begin
                                exp_words.push_back(f[(2*c)*W +: W]);
                                exp_words.push_back(f[(2*c+1)*W +: W]);
                            end
                        end
                    end
                end
                prev_req = IQ_RX_READ_REQ;

                if (BUS_SPI_enable && !prev_en) begin
                    if (exp_words.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL word_extra actual=%0h required=none at %0t", BUS_SPI_data_out, $time);
                    end else begin
                        check("word", {32'd0, BUS_SPI_data_out}, {32'd0, exp_words.pop_front()});
                    end
                    seen.push_back(BUS_SPI_data_out);
                    held = BUS_SPI_data_out;
                end else if (BUS_SPI_enable) begin
                    check("data_hold", {32'd0, BUS_SPI_data_out}, {32'd0, held});
                end
                if (BUS_SPI_enable) check("req_cover", {63'd0, IQ_RX_READ_REQ}, 64'd1);
                prev_en = BUS_SPI_enable;
            end
            check("level", {61'd0, fifo_level}, 64'(mdl_data.size()));
            check("overflow", {48'd0, overflow_count}, 64'(mdl_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge: presents one strobe for the next rising edge.
    task automatic push(input logic [CH-1:0] m, input logic [CH*2*W-1:0] d);
        iq_valid    = 1'b1;
        chan_enable = m;
        iq_data     = d;
        @(negedge clk_in);
        iq_valid    = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            if (!IQ_RX_READ_REQ && !BUS_SPI_enable && fifo_level == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check({"idle_", name}, {63'd0, ok}, 64'd1);
    endtask

    task automatic compare_seen(input string name);
        check({name, "_count"}, 64'(seen.size()), 64'(want.size()));
        for (int i = 0; i < want.size() && i < seen.size(); i++) begin
            check($sformatf("%s_w%0d", name, i), {32'd0, seen[i]}, {32'd0, want[i]});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic ok;
        reset       = 1'b1;
        iq_valid    = 1'b0;
        iq_data     = '0;
        chan_enable = '0;
        repeat (3) @(negedge clk_in);
        check("reset_enable", {63'd0, BUS_SPI_enable}, 64'd0);
        check("reset_req", {63'd0, IQ_RX_READ_REQ}, 64'd0);
        check("reset_level", {61'd0, fifo_level}, 64'd0);
        check("reset_ovf", {48'd0, overflow_count}, 64'd0);
        reset = 1'b0;
        @(negedge clk_in);

        // Test 1: both channels, latency and word order.
        seen.delete();
        push(2'b11, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        check("lat_level_t", {61'd0, fifo_level}, 64'd1);
        check("lat_req_t", {63'd0, IQ_RX_READ_REQ}, 64'd0);
        @(negedge clk_in);
        check("lat_req_t1", {63'd0, IQ_RX_READ_REQ}, 64'd1);
        check("lat_en_t1", {63'd0, BUS_SPI_enable}, 64'd0);
        @(negedge clk_in);
        check("lat_en_t2", {63'd0, BUS_SPI_enable}, 64'd1);
`ifdef IQ_STREAM_HEADER_EN
        check("lat_data_t2", {32'd0, BUS_SPI_data_out}, 64'hA5000003);
`else
        check("lat_data_t2", {32'd0, BUS_SPI_data_out}, 64'h11111111);
`endif
        wait_idle("t1", 200);
`ifdef IQ_STREAM_HEADER_EN
        want = {32'hA5000003, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
`else
        want = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
`endif
        compare_seen("t1");

        // Test 2: channel 0 masked off.
        seen.delete();
        push(2'b10, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        wait_idle("t2", 200);
`ifdef IQ_STREAM_HEADER_EN
        want = {32'hA5000102, 32'h33333333, 32'h44444444};
`else
        want = {32'h33333333, 32'h44444444};
`endif
        compare_seen("t2");

        // Test 3: empty mask is ignored entirely.
        seen.delete();
        push(2'b00, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        repeat (8) @(negedge clk_in);
        check("t3_words", 64'(seen.size()), 64'd0);
        check("t3_req", {63'd0, IQ_RX_READ_REQ}, 64'd0);
        check("t3_ovf", {48'd0, overflow_count}, 64'd0);

        // Test 4: shifter stuck busy, six strobes into a depth-4 FIFO.
        hold_busy = 1'b1;
        push(2'b11, {32'hA0000004, 32'hA0000003, 32'hA0000002, 32'hA0000001});
        repeat (4) @(negedge clk_in);
        for (int n = 2; n <= 6; n++) begin
            push(2'b11, {W'(32'hA0000004 + n * 16), W'(32'hA0000003 + n * 16),
                         W'(32'hA0000002 + n * 16), W'(32'hA0000001 + n * 16)});
        end
        check("t4_level", {61'd0, fifo_level}, 64'd4);
        check("t4_ovf", {48'd0, overflow_count}, 64'd1);

        // Test 5: strobe lands on the same edge as the pop of a full FIFO.
        hold_busy = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_in);
            if (!IQ_RX_READ_REQ) begin
                ok = 1'b1;
                break;
            end
        end
        check("t5_frame_end", {63'd0, ok}, 64'd1);
        push(2'b01, {32'hB0000004, 32'hB0000003, 32'hB0000002, 32'hB0000001});
        check("t5_level", {61'd0, fifo_level}, 64'd4);
        check("t5_ovf", {48'd0, overflow_count}, 64'd1);
        wait_idle("t5", 1000);
        check("t5_drained", 64'(exp_words.size()), 64'd0);

        // Test 6: reset while waiting for busy.
        mute_busy = 1'b1;
        push(2'b11, {32'hC0000004, 32'hC0000003, 32'hC0000002, 32'hC0000001});
        push(2'b01, {32'hC1000004, 32'hC1000003, 32'hC1000002, 32'hC1000001});
        repeat (3) @(negedge clk_in);
        check("t6_pre_en", {63'd0, BUS_SPI_enable}, 64'd1);
        check("t6_pre_level", {61'd0, fifo_level}, 64'd1);
        reset = 1'b1;
        @(negedge clk_in);
        check("t6_en", {63'd0, BUS_SPI_enable}, 64'd0);
        check("t6_req", {63'd0, IQ_RX_READ_REQ}, 64'd0);
        check("t6_level", {61'd0, fifo_level}, 64'd0);
        check("t6_ovf", {48'd0, overflow_count}, 64'd0);
        reset     = 1'b0;
        mute_busy = 1'b0;
        @(negedge clk_in);

        // Test 7: two channel-0 frames back to back after reset.
        seen.delete();
        push(2'b01, {32'h0C0C0004, 32'h0C0C0003, 32'h0C0C0002, 32'h0C0C0001});
        push(2'b01, {32'h0D0D0004, 32'h0D0D0003, 32'h0D0D0002, 32'h0D0D0001});
        wait_idle("t7", 300);
`ifdef IQ_STREAM_HEADER_EN
        want = {32'hA5000001, 32'h0C0C0001, 32'h0C0C0002,
                32'hA5000101, 32'h0D0D0001, 32'h0D0D0002};
`else
        want = {32'h0C0C0001, 32'h0C0C0002, 32'h0D0D0001, 32'h0D0D0002};
`endif
        compare_seen("t7");
        check("leftover", 64'(exp_words.size()), 64'd0);

        repeat (2) @(negedge clk_in);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_spi_streamer.md
Name: iq_spi_streamer

Overview:
- Parametrised successor to the single-channel RX1 I/Q SPI readout.
- Accepts one frame per sample strobe, holding I and Q for CHANNELS receivers, and buffers frames in a small FIFO.
- Serialises the enabled channels word-by-word to the bus SPI shifter over its enable/busy handshake.
- Adds per-channel masking, overflow accounting and level reporting, none of which the single-channel readout had.

Parameters:
- CHANNELS, 2: number of RX channels; each carries one I and one Q word.
- SAMPLE_W, 32: width of each I/Q word and of the SPI word.
- FIFO_DEPTH, 4: frames buffered; must be a power of 2 and ≥2.

Ports:
- clk_in  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- iq_valid  in  1  one-cycle strobe; a new frame is present on iq_data.
- iq_data  in  CHANNELS*2*SAMPLE_W  packed frame; ch0 I in the LSBs, then ch0 Q, ch1 I, ch1 Q, ...
- chan_enable  in  CHANNELS  channel mask, sampled at push.
- BUS_SPI_busy  in  1  shifter busy.
- BUS_SPI_data_out  out  SAMPLE_W  word to shift.
- BUS_SPI_enable  out  1  word-start request to the shifter.
- IQ_RX_READ_REQ  out  1  high from the first word of a frame until its last word completes.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames stored.
- overflow_count  out  16  dropped frames; saturates at 16'hFFFF.

Behaviour:
- Reset values: all outputs 0; FIFO emptied; FSM in IDLE; sequence counter 0.
  - Reset mid-transfer drops BUS_SPI_enable in the same edge and discards the partial frame.
- Push: on iq_valid with chan_enable != 0, the frame and mask are written at that clk_in edge.
  - A full FIFO drops the frame and increments overflow_count.
  - chan_enable == 0: the frame is ignored and not counted.
  - Push and pop in the same cycle while full: the push is accepted and the level is unchanged.
- FSM states: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE.
  - IDLE -> LOAD when the FIFO is not empty. LOAD pops the head frame, selects the first enabled word and asserts IQ_RX_READ_REQ.
  - LOAD -> START: drive BUS_SPI_data_out with the word and set BUS_SPI_enable=1.
  - START -> WAIT_BUSY, held until BUS_SPI_busy=1.
  - WAIT_BUSY -> WAIT_DONE, held until BUS_SPI_busy=0, then set BUS_SPI_enable=0.
  - After WAIT_DONE: if enabled words remain, go to START with the next word; otherwise clear IQ_RX_READ_REQ and go to IDLE.
  - IDLE with the FIFO still non-empty goes directly to LOAD (no extra idle cycle).
- Word order: ch0 I, ch0 Q, ch1 I, ... Disabled channels are skipped entirely, both I and Q.
- Latency: iq_valid at cycle t with the FIFO empty and the FSM idle gives LOAD at t+1 and BUS_SPI_enable=1 from t+2.
- BUS_SPI_data_out holds stable while BUS_SPI_enable=1.
- fifo_level counts pushes minus pops; it wraps never and saturates never, because it is bounded by DEPTH.

Optional Feature:
- Macro IQ_STREAM_HEADER_EN.
- Defined: each frame is preceded by one header word. Header word layout:
  - [SAMPLE_W-1:SAMPLE_W-8] = 8'hA5.
  - [23:8] = 16-bit frame sequence number. It increments per transmitted frame, wraps FFFF->0000 and is not advanced by dropped frames.
  - [7:0] = channel mask, zero-extended.
  - The header uses the same START/WAIT handshake, and IQ_RX_READ_REQ rises with the header.
- Undefined: no header and no sequence counter; data words only.

Decomposition:
- Package iq_stream_pkg holds:
  - the FSM state enum;
  - HDR_SYNC = 8'hA5;
  - the word-index width function, $clog2(2*CHANNELS);
  - frame-width helper constants.
- Sub-module iq_frame_fifo: synchronous FIFO of frame+mask with full/empty/level and a same-cycle push/pop rule.
- FSM and serialiser remain in the top.

Test Plan:
- CHANNELS=2, mask=2'b11, one frame {I0=11111111, Q0=22222222, I1=33333333, Q1=44444444}; shifter busy 3 cycles/word.
  - Expect 4 words in that order, BUS_SPI_enable rising at t+2, IQ_RX_READ_REQ high over all 4 words, fifo_level back to 0.
- mask=2'b10 -> only 33333333 and 44444444 sent. mask=2'b00 -> nothing sent, overflow_count unchanged.
- Hold BUS_SPI_busy=1 permanently and issue 6 strobes with DEPTH=4.
  - Expect fifo_level=4 after the first frame is popped into the FSM and further frames arrive, and overflow_count=1.
- Full FIFO with a pop and iq_valid in the same cycle -> frame accepted, overflow_count unchanged, level stays 4.
- Assert reset while in WAIT_BUSY -> next edge shows BUS_SPI_enable=0, IQ_RX_READ_REQ=0, fifo_level=0, overflow_count=0.
- With IQ_STREAM_HEADER_EN, send 2 frames of mask 2'b01.
  - Expect headers A5000001 and A5000101, each followed by the I and Q words.
  - After 65536 frames the sequence field wraps to 0000.
